// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side scheduler.
package uart_pkg;

  // Capture FSM states of the receive scheduler.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEARING = 2'd1,
    WAIT_ARM = 2'd2
  } uart_rx_sched_state_t;

  // Bus word that means "no data" on the CPU read port.
  localparam logic [15:0] UART_EMPTY_WORD = 16'h8000;

  // Width of one received character.
  localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide synchronous FIFO with push, pop, flush, occupancy count and
// full/empty flags. A pop on an empty FIFO is ignored; a push into a full
// FIFO only lands when a same-cycle pop makes room. Flush overrides both.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_BYTE_W-1:0] push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [UART_BYTE_W-1:0] head,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // Storage write; a flushed push is discarded.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_sched.sv
// Receive-side controller: captures each completed deserializer byte exactly
// once, re-arms the deserializer with a one-cycle rx_clear pulse, buffers the
// bytes in a FIFO and serves them on a CPU read port (bit 15 set = no data).
// Optional build macro UART_RX_SCHED_ERRCNT_EN adds a saturating dropped-byte
// counter on output err_count.
module uart_rx_sched
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   rx_out,
  output logic          rx_clear,
  input  logic          rd,
  output logic [15:0]   rd_data,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          overrun
`ifdef UART_RX_SCHED_ERRCNT_EN
  ,
  output logic [7:0]    err_count
`endif
);

  uart_rx_sched_state_t   state_reg;
  logic                   rx_clear_reg;
  logic                   overrun_reg;
  logic                   push_req;
  logic                   pop_ok;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_head;
  logic                   unused_rx_bits;

  // Upper payload bits carry no information; only bit 15 and the byte matter.
  assign unused_rx_bits = ^rx_out[14:8];

  // A new frame is taken only while armed and the deserializer shows data.
  assign push_req = (state_reg == IDLE) && !rx_out[15];
  assign pop_ok   = rd && !fifo_empty;
  // A byte is lost when it arrives at a full FIFO with no pop to make room.
  assign drop     = push_req && fifo_full && !pop_ok && !flush;

  assign rd_data  = fifo_empty ? UART_EMPTY_WORD : {8'd0, fifo_head};
  assign rx_clear = rx_clear_reg;
  assign overrun  = overrun_reg;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (rx_out[UART_BYTE_W-1:0]),
    .pop       (rd),
    .flush     (flush),
    .head      (fifo_head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Capture FSM: grab, pulse clear, then wait for the deserializer to go idle
  // so a held result word cannot be captured twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rx_clear_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!rx_out[15]) begin
            rx_clear_reg <= 1'b1;
            state_reg    <= CLEARING;
          end
        end
        CLEARING: begin
          rx_clear_reg <= 1'b0;
          state_reg    <= WAIT_ARM;
        end
        WAIT_ARM: begin
          if (rx_out[15]) state_reg <= IDLE;
        end
        default: begin
          rx_clear_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; flush clears it and takes priority over a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (flush) begin
      overrun_reg <= 1'b0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
    end
  end

`ifdef UART_RX_SCHED_ERRCNT_EN
  logic [7:0] err_count_reg;

  assign err_count = err_count_reg;

  // Saturating count of dropped bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= 8'd0;
    end else if (flush) begin
      err_count_reg <= 8'd0;
    end else if (drop && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end
`endif

endmodule

// File: doc/uart_rx_sched.md
# uart_rx_sched

Receive-side controller for the byte-serial UART deserializer. It watches the deserializer's 16-bit result word, moves each completed byte into a small FIFO, and pulses the deserializer's `clear` to re-arm it for the next frame. It gives the CPU a memory-mapped read port that uses the codebase's I/O convention: bit 15 set means no data. It sits between the UART receiver and the CPU data bus.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes; must be a power of two and at least 2.
- `CW`, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `rx_out`  in  16: deserializer result word; bit 15 = 1 means idle/empty, otherwise `{8'd0, byte}`.
- `rx_clear`  out  1: re-arm pulse to the deserializer's `clear`; high for one cycle.
- `rd`  in  1: CPU read strobe; pops one byte when the FIFO is not empty.
- `rd_data`  out  16: combinational; `{8'd0, head}` when not empty, `16'h8000` when empty.
- `flush`  in  1: synchronous FIFO/status clear.
- `count`  out  CW: FIFO occupancy.
- `overrun`  out  1: sticky; set when a byte is dropped.

## Operation
- FSM states: `IDLE`, `CLEARING`, `WAIT_ARM`.
  - `IDLE`: at an edge where `rx_out[15]==0`, push `rx_out[7:0]`, set `rx_clear<=1`, go to `CLEARING`.
  - `CLEARING`: `rx_clear<=0`, go to `WAIT_ARM`.
  - `WAIT_ARM`: stay until `rx_out[15]==1`, then go to `IDLE`. This guarantees each frame is captured exactly once.
- Push when full:
  - Without a simultaneous pop, the byte is dropped and `overrun<=1`. `rx_clear` still pulses, so the receiver never stalls.
  - With a simultaneous pop, both happen and `count` is unchanged.
- Pop: `rd && count!=0`. The head advances at the edge, so `rd_data` shows the next byte in the following cycle.
- `rd` while empty: returns `16'h8000`. No state change.
- Push and pop while empty: the push happens, the pop is ignored, and `count` becomes 1.
- `flush`: empties the FIFO (pointers and `count` to 0) and clears `overrun`. Flush beats a same-cycle push or pop, and the pushed byte is discarded. The FSM is not affected.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` ranges 0..DEPTH.

## Timing
- Reset values: `rx_clear=0`, `count=0`, `overrun=0`, `rd_data=16'h8000`, state `IDLE`, pointers 0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous). Any in-flight byte is lost.
  - On release, if `rx_out[15]==0` the pending byte is captured at the first edge.
- Capture latency:
  - `rx_out` becomes valid before edge N.
  - At edge N: byte written, `count+1`, `rx_clear` high.
  - At edge N+1: the deserializer clears and `rx_clear` falls.
  - `rd_data` reflects the byte after edge N if the FIFO was empty.
- Minimum capture spacing: 3 cycles. This is far shorter than one UART frame.

## Configuration
- `UART_RX_SCHED_ERRCNT_EN`:
  - Defined: adds output `err_count [7:0]`. It increments on every dropped byte, saturates at 255, and is cleared by `flush` and by reset.
  - Undefined: the port and counter are absent. `overrun` behaviour is identical in both builds.

## Structure
- Package `uart_pkg`:
  - FSM state enum `uart_rx_sched_state_t`.
  - `UART_EMPTY_WORD = 16'h8000`.
  - `UART_BYTE_W = 8`.
- Sub-module `uart_byte_fifo`: synchronous FIFO with push, pop, flush, count and full/empty. The controller owns the FSM, overrun and error-count logic.

## Test plan
- Single byte:
  - Stimulus: after reset, drive `rx_out=16'h0041`.
  - Required: `rx_clear` pulses for one cycle, `count=1`, `rd_data=16'h0041`.
  - Then `rd` → `count=0`, `rd_data=16'h8000`.
- Hold without re-arm: keep `rx_out=16'h0041` for 5 cycles after the clear pulse (deserializer does not respond) → exactly one push and one `rx_clear` pulse.
- Full and overrun:
  - Push 16 bytes `0x00..0x0F` → `count=16`.
  - A 17th byte `0x55` → dropped and `overrun=1`.
  - Reads return `0x00..0x0F` in order.
  - `err_count=1` when the macro is defined.
- Full, push with read: `count=16`, push `0xAA` together with `rd` → `count=16`, `overrun=0`. The last byte read out after draining is `0xAA`.
- Flush and reset:
  - `flush` in the same cycle as a push → `count=0` and `overrun=0`.
  - Assert `rst_n=0` in `CLEARING` → `rx_clear=0` and `count=0` immediately.
